axi_if_rd_burst_splitter: RTL and testbench

Converts byte-addressed read commands (start address, byte size) into a sequence of AXI4 AR-channel bursts. Each burst is INCR, full data-width beats, at most MAX_BURST_BEATS beats, and never crosses a PAGE_BYTES (4096) boundary. It sits between the DMA/command logic and the AXI4 read master port. Downstream R-data handling uses the per-burst ar_cmd_last sideband.

---
 rtl/axi_if_common_param_pkg.sv | 21 ++
 rtl/axi_if_burst_calc.sv | 41 ++++
 rtl/axi_if_rd_burst_splitter.sv | 120 ++++++++++++
 tb/tb_axi_if_rd_burst_splitter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_if_common_param_pkg.sv
// Shared AXI4 interface constants for the read/write burst splitters.
//   PAGE_BYTES / PAGE_BYTES_W : boundary no burst may cross, and its log2
//   AXI4_LEN_W / AXI4_SIZE_W / AXI4_BURST_W : AR/AW channel field widths
//   AXI4_MAX_BURST_BEATS : AXI4 INCR burst beat limit
//   axi4_burst_mode_e : AxBURST encodings
package axi_if_common_param_pkg;

   localparam int unsigned PAGE_BYTES           = 4096;
   localparam int unsigned PAGE_BYTES_W         = $clog2(PAGE_BYTES);
   localparam int unsigned AXI4_LEN_W           = 8;
   localparam int unsigned AXI4_SIZE_W          = 3;
   localparam int unsigned AXI4_BURST_W         = 2;
   localparam int unsigned AXI4_MAX_BURST_BEATS = 256;

   typedef enum logic [AXI4_BURST_W-1:0] {
      AXI4B_FIXED = 2'b00,
      AXI4B_INCR  = 2'b01,
      AXI4B_WRAP  = 2'b10
   } axi4_burst_mode_e;

endpackage

// File: rtl/axi_if_burst_calc.sv
// Combinational beat count for the next burst of a split command.
//   addr_i  : page-offset bits of the current burst address (beat-aligned)
//   rem_i   : beats still owed to the command
//   beats_o : min(beats to page end, MAX_BEATS, rem_i)
//   last_o  : this burst drains the command (beats_o == rem_i)
module axi_if_burst_calc
   import axi_if_common_param_pkg::*;
#(
   parameter int unsigned BPB_W     = 6,
   parameter int unsigned REM_W     = 27,
   parameter int unsigned MAX_BEATS = AXI4_MAX_BURST_BEATS
) (
   input  logic [PAGE_BYTES_W-1:0] addr_i,
   input  logic [REM_W-1:0]        rem_i,
   output logic [AXI4_LEN_W:0]     beats_o,
   output logic                    last_o
);

   // Common compare width: wide enough for a full page count and for rem_i.
   localparam int unsigned CW = (REM_W > PAGE_BYTES_W + 1) ? REM_W : PAGE_BYTES_W + 1;

   logic [CW-1:0] page_left;
   logic [CW-1:0] page_beats;
   logic [CW-1:0] rem_ext;
   logic [CW-1:0] cap;
   logic [CW-1:0] min_pc;
   logic [CW-1:0] min_all;

   always_comb begin
      // A page-aligned address yields a full page, never zero.
      page_left  = CW'(PAGE_BYTES) - CW'(addr_i);
      page_beats = page_left >> BPB_W;
      cap        = CW'(MAX_BEATS);
      rem_ext    = CW'(rem_i);
      min_pc     = (page_beats < cap) ? page_beats : cap;
      min_all    = (min_pc < rem_ext) ? min_pc : rem_ext;
      beats_o    = (AXI4_LEN_W + 1)'(min_all);
      last_o     = (min_all == rem_ext);
   end

endmodule

// File: rtl/axi_if_rd_burst_splitter.sv
// Splits a byte-addressed read command into AXI4 INCR AR bursts that never
// exceed MAX_BURST_BEATS beats nor cross a PAGE_BYTES boundary.
//   clk, a_rst_n                  : clock, asynchronous active-low reset
//   cmd_add/cmd_size/cmd_vld/rdy  : command in (BPB-aligned address, byte size)
//   m_axi4_ar*                    : AXI4 AR channel out (full-width INCR beats)
//   ar_cmd_last                   : with arvalid, marks the final burst of a command
module axi_if_rd_burst_splitter
   import axi_if_common_param_pkg::*;
#(
   parameter int unsigned AXI4_ADD_W      = 64,
   parameter int unsigned AXI4_DATA_W     = 512,
   parameter int unsigned CMD_SIZE_W      = 32,
   parameter int unsigned MAX_BURST_BEATS = AXI4_MAX_BURST_BEATS
) (
   input  logic                    clk,
   input  logic                    a_rst_n,
   input  logic [AXI4_ADD_W-1:0]   cmd_add,
   input  logic [CMD_SIZE_W-1:0]   cmd_size,
   input  logic                    cmd_vld,
   output logic                    cmd_rdy,
   output logic [AXI4_ADD_W-1:0]   m_axi4_araddr,
   output logic [AXI4_LEN_W-1:0]   m_axi4_arlen,
   output logic [AXI4_SIZE_W-1:0]  m_axi4_arsize,
   output logic [AXI4_BURST_W-1:0] m_axi4_arburst,
   output logic                    m_axi4_arvalid,
   input  logic                    m_axi4_arready,
   output logic                    ar_cmd_last
);

   localparam int unsigned BPB     = AXI4_DATA_W / 8;
   localparam int unsigned BPB_W   = $clog2(BPB);
   localparam int unsigned REM_W   = CMD_SIZE_W - BPB_W + 1;
   localparam int unsigned BEATS_W = AXI4_LEN_W + 1;
   localparam logic [AXI4_ADD_W-1:0] LOW_MASK = AXI4_ADD_W'(BPB - 1);

   typedef enum logic {StIdle, StSplit} split_state_e;

   split_state_e          state_q, state_d;
   logic [AXI4_ADD_W-1:0] addr_q, addr_d;
   logic [REM_W-1:0]      rem_q, rem_d;

   logic [BEATS_W-1:0]    beats;
   logic                  burst_last;
   logic [CMD_SIZE_W:0]   size_rnd;
   logic [REM_W-1:0]      rem_new;

   axi_if_burst_calc #(
      .BPB_W     (BPB_W),
      .REM_W     (REM_W),
      .MAX_BEATS (MAX_BURST_BEATS)
   ) u_burst_calc (
      .addr_i  (addr_q[PAGE_BYTES_W-1:0]),
      .rem_i   (rem_q),
      .beats_o (beats),
      .last_o  (burst_last)
   );

   // Round the byte size up to whole beats; one extra bit absorbs the carry.
   assign size_rnd = {1'b0, cmd_size} + (CMD_SIZE_W + 1)'(BPB - 1);
   assign rem_new  = REM_W'(size_rnd >> BPB_W);

   assign m_axi4_araddr  = addr_q;
   assign m_axi4_arsize  = AXI4_SIZE_W'(BPB_W);
   assign m_axi4_arburst = AXI4B_INCR;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      rem_d          = rem_q;
      cmd_rdy        = 1'b0;
      m_axi4_arvalid = 1'b0;
      m_axi4_arlen   = '0;
      ar_cmd_last    = 1'b0;
      unique case (state_q)
         StIdle: begin
            cmd_rdy = 1'b1;
            if (cmd_vld) begin
               addr_d = cmd_add & ~LOW_MASK;
               rem_d  = rem_new;
               // A zero-byte command is consumed without issuing a burst.
               if (rem_new != '0) begin
                  state_d = StSplit;
               end
            end
         end
         StSplit: begin
            m_axi4_arvalid = 1'b1;
            m_axi4_arlen   = AXI4_LEN_W'(beats - BEATS_W'(1));
            ar_cmd_last    = burst_last;
            if (m_axi4_arready) begin
               addr_d = addr_q + (AXI4_ADD_W'(beats) << BPB_W);
               rem_d  = rem_q - REM_W'(beats);
               if (burst_last) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
      end
   end

`ifndef SYNTHESIS
   cmd_add_aligned_a : assert property (@(posedge clk) disable iff (!a_rst_n)
      (cmd_vld && cmd_rdy) |-> ((cmd_add & LOW_MASK) == '0))
      else $error("cmd_add not beat-aligned: %h", cmd_add);
`endif

endmodule

// File: tb/tb_axi_if_rd_burst_splitter.sv
module tb_axi_if_rd_burst_splitter;
   import axi_if_common_param_pkg::*;

   localparam int unsigned AW = 64;
   localparam int unsigned SW = 32;

   logic          clk = 1'b0;
   logic          a_rst_n = 1'b0;
   logic [AW-1:0] cmd_add = '0;
   logic [SW-1:0] cmd_size = '0;
   logic          cmd_vld = 1'b0;
   logic          cmd_vld16 = 1'b0;
   logic          arready = 1'b1;

   logic          cmd_rdy, arvalid, last;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;

   logic          cmd_rdy16, arvalid16, last16;
   logic [AW-1:0] araddr16;
   logic [7:0]    arlen16;
   logic [2:0]    arsize16;
   logic [1:0]    arburst16;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axi_if_rd_burst_splitter #(
      .AXI4_ADD_W (AW), .AXI4_DATA_W (512), .CMD_SIZE_W (SW), .MAX_BURST_BEATS (256)
   ) dut (
      .clk (clk), .a_rst_n (a_rst_n), .cmd_add (cmd_add), .cmd_size (cmd_size),
      .cmd_vld (cmd_vld), .cmd_rdy (cmd_rdy), .m_axi4_araddr (araddr),
      .m_axi4_arlen (arlen), .m_axi4_arsize (arsize), .m_axi4_arburst (arburst),
      .m_axi4_arvalid (arvalid), .m_axi4_arready (arready), .ar_cmd_last (last)
   );

   axi_if_rd_burst_splitter #(
      .AXI4_ADD_W (AW), .AXI4_DATA_W (512), .CMD_SIZE_W (SW), .MAX_BURST_BEATS (16)
   ) dut16 (
      .clk (clk), .a_rst_n (a_rst_n), .cmd_add (cmd_add), .cmd_size (cmd_size),
      .cmd_vld (cmd_vld16), .cmd_rdy (cmd_rdy16), .m_axi4_araddr (araddr16),
      .m_axi4_arlen (arlen16), .m_axi4_arsize (arsize16), .m_axi4_arburst (arburst16),
      .m_axi4_arvalid (arvalid16), .m_axi4_arready (arready), .ar_cmd_last (last16)
   );

   // Drive one command for a single cycle; returns on the negedge after the handshake.
   task automatic drive_cmd(input logic [AW-1:0] a, input logic [SW-1:0] s, input bit sel16);
      @(negedge clk);
      cmd_add  = a;
      cmd_size = s;
      if (sel16) cmd_vld16 = 1'b1;
      else       cmd_vld   = 1'b1;
      @(negedge clk);
      cmd_vld   = 1'b0;
      cmd_vld16 = 1'b0;
   endtask

   task automatic test_reset();
      a_rst_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if (arvalid !== 1'b0) begin
         n_err++; $display("FAIL reset_arvalid: got %b want 0", arvalid);
      end
      n_vec++;
      if (araddr !== 64'h0) begin
         n_err++; $display("FAIL reset_araddr: got %h want 0", araddr);
      end
      n_vec++;
      if (arlen !== 8'd0) begin
         n_err++; $display("FAIL reset_arlen: got %0d want 0", arlen);
      end
      n_vec++;
      if (last !== 1'b0) begin
         n_err++; $display("FAIL reset_last: got %b want 0", last);
      end
      n_vec++;
      if (cmd_rdy !== 1'b1 || cmd_rdy16 !== 1'b1) begin
         n_err++; $display("FAIL reset_cmd_rdy: got %b/%b want 1/1", cmd_rdy, cmd_rdy16);
      end
      n_vec++;
      if (arsize !== 3'd6) begin
         n_err++; $display("FAIL reset_arsize: got %0d want 6", arsize);
      end
      n_vec++;
      if (arburst !== 2'b01) begin
         n_err++; $display("FAIL reset_arburst: got %b want 01", arburst);
      end
      a_rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_page();
      arready = 1'b1;
      drive_cmd(64'h0, 32'd4096, 1'b0);
      n_vec++;
      if ({arvalid, araddr, arlen, last} !== {1'b1, 64'h0, 8'd63, 1'b1}) begin
         n_err++;
         $display("FAIL single_page_burst: got v=%b a=%h len=%0d last=%b want v=1 a=0 len=63 last=1",
                  arvalid, araddr, arlen, last);
      end
      n_vec++;
      if (cmd_rdy !== 1'b0) begin
         n_err++; $display("FAIL single_page_busy: got cmd_rdy=%b want 0", cmd_rdy);
      end
      @(negedge clk);
      n_vec++;
      if (arvalid !== 1'b0 || cmd_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL single_page_done: got v=%b rdy=%b want v=0 rdy=1", arvalid, cmd_rdy);
      end
   endtask

   task automatic test_page_cross();
      logic [AW-1:0] ea [0:1];
      logic [7:0]    el [0:1];
      logic          ex [0:1];
      ea[0] = 64'hFC0;  el[0] = 8'd0; ex[0] = 1'b0;
      ea[1] = 64'h1000; el[1] = 8'd2; ex[1] = 1'b1;
      arready = 1'b1;
      drive_cmd(64'hFC0, 32'd256, 1'b0);
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if ({arvalid, araddr, arlen, last} !== {1'b1, ea[i], el[i], ex[i]}) begin
            n_err++;
            $display("FAIL page_cross_burst%0d: got v=%b a=%h len=%0d last=%b want v=1 a=%h len=%0d last=%b",
                     i, arvalid, araddr, arlen, last, ea[i], el[i], ex[i]);
         end
         @(negedge clk);
      end
      n_vec++;
      if (arvalid !== 1'b0 || cmd_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL page_cross_done: got v=%b rdy=%b want v=0 rdy=1", arvalid, cmd_rdy);
      end
   endtask

   task automatic test_partial_beat();
      arready = 1'b1;
      drive_cmd(64'h1000, 32'd100, 1'b0);
      n_vec++;
      if ({arvalid, araddr, arlen, last} !== {1'b1, 64'h1000, 8'd1, 1'b1}) begin
         n_err++;
         $display("FAIL partial_beat_burst: got v=%b a=%h len=%0d last=%b want v=1 a=1000 len=1 last=1",
                  arvalid, araddr, arlen, last);
      end
      @(negedge clk);
      n_vec++;
      if (arvalid !== 1'b0 || cmd_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL partial_beat_done: got v=%b rdy=%b want v=0 rdy=1", arvalid, cmd_rdy);
      end
   endtask

   task automatic test_max_beats();
      logic [AW-1:0] ea [0:3];
      ea[0] = 64'h0; ea[1] = 64'h400; ea[2] = 64'h800; ea[3] = 64'hC00;
      arready = 1'b1;
      drive_cmd(64'h0, 32'd4096, 1'b1);
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if ({arvalid16, araddr16, arlen16, last16} !== {1'b1, ea[i], 8'd15, (i == 3)}) begin
            n_err++;
            $display("FAIL max_beats_burst%0d: got v=%b a=%h len=%0d last=%b want v=1 a=%h len=15 last=%b",
                     i, arvalid16, araddr16, arlen16, last16, ea[i], (i == 3));
         end
         @(negedge clk);
      end
      n_vec++;
      if (arvalid16 !== 1'b0 || cmd_rdy16 !== 1'b1) begin
         n_err++;
         $display("FAIL max_beats_done: got v=%b rdy=%b want v=0 rdy=1", arvalid16, cmd_rdy16);
      end
   endtask

   task automatic test_backpressure();
      arready = 1'b0;
      drive_cmd(64'hFC0, 32'd256, 1'b0);
      n_vec++;
      if ({arvalid, araddr, arlen, last} !== {1'b1, 64'hFC0, 8'd0, 1'b0}) begin
         n_err++;
         $display("FAIL backpressure_burst0: got v=%b a=%h len=%0d last=%b want v=1 a=fc0 len=0 last=0",
                  arvalid, araddr, arlen, last);
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         n_vec++;
         if ({arvalid, araddr, arlen, last} !== {1'b1, 64'h1000, 8'd2, 1'b1}) begin
            n_err++;
            $display("FAIL backpressure_hold%0d: got v=%b a=%h len=%0d last=%b want v=1 a=1000 len=2 last=1",
                     i, arvalid, araddr, arlen, last);
         end
         @(negedge clk);
      end
      arready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (arvalid !== 1'b0 || cmd_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL backpressure_done: got v=%b rdy=%b want v=0 rdy=1", arvalid, cmd_rdy);
      end
   endtask

   task automatic test_zero_size();
      arready = 1'b1;
      drive_cmd(64'h2000, 32'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (arvalid !== 1'b0 || cmd_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL zero_size_idle%0d: got v=%b rdy=%b want v=0 rdy=1", i, arvalid, cmd_rdy);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_addr_wrap();
      arready = 1'b1;
      drive_cmd(64'hFFFF_FFFF_FFFF_FFC0, 32'd128, 1'b0);
      n_vec++;
      if ({arvalid, araddr, arlen, last} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFC0, 8'd0, 1'b0}) begin
         n_err++;
         $display("FAIL wrap_burst0: got v=%b a=%h len=%0d last=%b want v=1 a=ffffffffffffffc0 len=0 last=0",
                  arvalid, araddr, arlen, last);
      end
      @(negedge clk);
      n_vec++;
      if ({arvalid, araddr, arlen, last} !== {1'b1, 64'h0, 8'd0, 1'b1}) begin
         n_err++;
         $display("FAIL wrap_burst1: got v=%b a=%h len=%0d last=%b want v=1 a=0 len=0 last=1",
                  arvalid, araddr, arlen, last);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] ea [0:1];
      logic          ex [0:1];
      ea[0] = 64'hF00;  ex[0] = 1'b0;
      ea[1] = 64'h1000; ex[1] = 1'b1;
      arready = 1'b1;
      drive_cmd(64'h0, 32'd4096, 1'b1);
      n_vec++;
      if ({arvalid16, araddr16} !== {1'b1, 64'h0}) begin
         n_err++; $display("FAIL reset_mid_first: got v=%b a=%h want v=1 a=0", arvalid16, araddr16);
      end
      @(negedge clk);
      a_rst_n = 1'b0;
      #1;
      n_vec++;
      if (arvalid16 !== 1'b0) begin
         n_err++; $display("FAIL reset_mid_async_drop: got v=%b want 0", arvalid16);
      end
      @(negedge clk);
      @(negedge clk);
      a_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_vec++;
         if (arvalid16 !== 1'b0 || cmd_rdy16 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_quiet%0d: got v=%b rdy=%b want v=0 rdy=1", i, arvalid16, cmd_rdy16);
         end
      end
      drive_cmd(64'hF00, 32'd512, 1'b1);
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if ({arvalid16, araddr16, arlen16, last16} !== {1'b1, ea[i], 8'd3, ex[i]}) begin
            n_err++;
            $display("FAIL reset_mid_new%0d: got v=%b a=%h len=%0d last=%b want v=1 a=%h len=3 last=%b",
                     i, arvalid16, araddr16, arlen16, last16, ea[i], ex[i]);
         end
         @(negedge clk);
      end
      n_vec++;
      if (arvalid16 !== 1'b0 || cmd_rdy16 !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid_done: got v=%b rdy=%b want v=0 rdy=1", arvalid16, cmd_rdy16);
      end
   endtask

   initial begin
      test_reset();
      test_single_page();
      test_page_cross();
      test_partial_beat();
      test_max_beats();
      test_backpressure();
      test_zero_size();
      test_addr_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
